airi5c_dm_regaccess: RTL and testbench
======================================

Name: airi5c_dm_regaccess

Overview:
- Abstract-command "Access Register" engine inside the airi5c debug module; initiator side of the register-file debug port (address/write-data/write-enable out, read-data in).
- Takes one abstract command word from the DMI decode logic and checks it. Either writes data0 into a GPR/FPR, or reads a GPR/FPR into data0.
- Reports busy and cmderr per RISC-V Debug Spec 0.13 abstract-command semantics.

Parameters:
- NUM_GPR, 32, integer registers implemented (16 for the E extension); regno 0x1000+NUM_GPR..0x101F is unsupported.
- HAS_FPU, 0, 1 enables FPR access at regno 0x1020..0x103F.
- XLEN, 32, data width; only aarsize=2 is legal.

Ports:
- clk_i  in  1  clock (one clock domain).
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  single-cycle pulse: DMI write to the command register.
- cmd_i  in  32  abstract command word: [31:24] cmdtype, [22:20] aarsize, [19] aarpostincrement, [18] postexec, [17] transfer, [16] write, [15:0] regno.
- data0_i  in  XLEN  current abstract data0 register.
- halted_i  in  1  hart is halted.
- cmderr_clr_i  in  3  W1C mask for cmderr from DMI abstractcs write.
- busy_o  out  1  command in progress.
- cmderr_o  out  3  sticky error code.
- data0_o  out  XLEN  read result.
- data0_we_o  out  1  one-cycle strobe: load data0_o into data0.
- cmd_upd_o  out  32  command word with regno incremented.
- cmd_upd_we_o  out  1  one-cycle strobe for a postincrement writeback.
- dm_wara_o  out  5  register file address.
- dm_wd_o  out  XLEN  register file write data.
- dm_wen_o  out  1  register file write enable.
- dm_sel_fpu_reg_o  out  1  selects the FPR bank.
- dm_rd_i  in  XLEN  combinational read data from the register file.

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - FSM goes to IDLE.
  - busy_o, cmderr_o, data0_we_o, cmd_upd_we_o, dm_wen_o and dm_sel_fpu_reg_o are 0.
  - dm_wara_o, dm_wd_o, data0_o and cmd_upd_o are 0.
  - Reset mid-command aborts the command with no register-file write.
- States: IDLE, DECODE, XFER, POST.
- IDLE:
  - Accepts cmd_valid_i only when cmderr_o==0. It latches cmd_i and data0_i, sets busy_o, and goes to DECODE.
  - If cmderr_o!=0, the command is ignored: no state change, cmderr unchanged.
- cmd_valid_i while busy_o=1: set cmderr=1 (busy) if cmderr is currently 0. The current command continues unaffected.
- DECODE checks errors in this priority order. The first hit sets cmderr and returns to IDLE; busy_o drops next cycle and nothing is written.
  - cmdtype!=0, or aarsize!=2 while transfer=1, or postexec=1 -> cmderr=2.
  - !halted_i -> cmderr=4.
  - transfer=1 and regno unsupported -> cmderr=3.
- Supported regno:
  - 0x1000..0x1000+NUM_GPR-1 for GPRs.
  - 0x1020..0x103F when HAS_FPU=1 (dm_sel_fpu_reg_o=1).
- DECODE with no error:
  - transfer=0 -> POST if aarpostincrement=1, else IDLE.
  - Otherwise -> XFER, driving dm_wara_o=regno[4:0] and the FPU select.
- XFER (exactly one cycle):
  - write=1: dm_wen_o=1 and dm_wd_o=latched data0.
  - write=0: data0_o captures dm_rd_i and data0_we_o pulses in that same cycle.
  - A read of x0 returns whatever the register file supplies (0).
  - Next state is POST if aarpostincrement=1, else IDLE.
- POST:
  - cmd_upd_o = latched command with regno+1; the 16-bit regno wraps 0xFFFF->0x0000.
  - cmd_upd_we_o pulses; next state IDLE.
- busy_o is 1 in DECODE, XFER and POST. A transfer without postincrement is busy for 2 cycles; with postincrement, 3 cycles.
- dm_wen_o is never asserted outside XFER. dm_wara_o holds its value outside XFER.
- cmderr:
  - cmderr <= cmderr & ~cmderr_clr_i every cycle.
  - A same-cycle error set overrides the clear.
  - cmderr is never overwritten while nonzero.

Decomposition:
- Shared package/header (rv32_opcodes/airi5c debug defines) holds:
  - the cmderr codes (NONE=0, BUSY=1, NOTSUP=2, EXC=3, HALTRESUME=4);
  - the field bit positions for cmdtype, aarsize, postinc, postexec, transfer, write and regno;
  - regno base constants GPR_BASE=0x1000 and FPR_BASE=0x1020;
  - the FSM state encodings.
- One natural sub-module, airi5c_dm_cmd_check: combinational command-legality check producing the error code and the FPU select.

Test Plan:
- Halted, cmd=0x00231005, data0=0xCAFEF00D -> busy 2 cycles; dm_wen_o=1 for one cycle with wara=5, wd=0xCAFEF00D; cmderr=0.
- Halted, cmd=0x00221003, dm_rd_i=0x12345678 -> data0_we_o pulse with data0_o=0x12345678; dm_wen_o never 1.
- Halted, cmd=0x002A1001 (read, postincrement) -> read of x1; busy 3 cycles; cmd_upd_we_o pulses with cmd_upd_o=0x002A1002.
- halted_i=0, cmd=0x00231002 -> cmderr=4, no write. Then cmd_valid_i again -> ignored. Then cmderr_clr_i=3'b111 -> cmderr=0.
- Two illegal commands, each issued from a cleared state:
  - cmd=0x00331002 (aarsize=3) -> cmderr=2.
  - cmd=0x00221021 with HAS_FPU=0 -> cmderr=3.
- Second cmd_valid_i one cycle after the first -> cmderr=1; first command still completes its write. rst_i asserted in DECODE -> no dm_wen_o, busy_o=0 after the edge.

Source files
------------

// File: rtl/airi5c_dm_regaccess_pkg.sv
// Shared definitions for the debug-module abstract "Access Register" command engine:
// cmderr codes, command-word field positions, regno bases and FSM states.
package airi5c_dm_regaccess_pkg;

   localparam logic [2:0] CMDERR_NONE       = 3'd0;
   localparam logic [2:0] CMDERR_BUSY       = 3'd1;
   localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
   localparam logic [2:0] CMDERR_EXC        = 3'd3;
   localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

   localparam int CMD_CMDTYPE_MSB = 31;
   localparam int CMD_CMDTYPE_LSB = 24;
   localparam int CMD_AARSIZE_MSB = 22;
   localparam int CMD_AARSIZE_LSB = 20;
   localparam int CMD_POSTINC     = 19;
   localparam int CMD_POSTEXEC    = 18;
   localparam int CMD_TRANSFER    = 17;
   localparam int CMD_WRITE       = 16;
   localparam int CMD_REGNO_MSB   = 15;
   localparam int CMD_REGNO_LSB   = 0;

   localparam logic [2:0]  AARSIZE_32 = 3'd2;
   localparam logic [15:0] GPR_BASE   = 16'h1000;
   localparam logic [15:0] FPR_BASE   = 16'h1020;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_XFER   = 2'd2,
      ST_POST   = 2'd3
   } ra_state_e;

endpackage

// File: rtl/airi5c_dm_cmd_check.sv
// Combinational legality check of a latched abstract command: error code in
// priority order (not supported, hart not halted, bad regno) plus FPR bank select.
module airi5c_dm_cmd_check
   import airi5c_dm_regaccess_pkg::*;
#(
   parameter int NUM_GPR = 32,
   parameter int HAS_FPU = 0
) (
   input  logic [31:0] cmd,
   input  logic        halted,
   output logic [2:0]  err,
   output logic        sel_fpu
);

   logic [15:0] regno;
   logic        transfer;
   logic        is_gpr;
   logic        is_fpr;
   logic        notsup;
   logic        unused_fields;

   assign regno    = cmd[CMD_REGNO_MSB:CMD_REGNO_LSB];
   assign transfer = cmd[CMD_TRANSFER];

   assign is_gpr = (regno >= GPR_BASE) && (regno < GPR_BASE + 16'(NUM_GPR));
   assign is_fpr = (HAS_FPU != 0) && (regno >= FPR_BASE) && (regno < FPR_BASE + 16'd32);

   assign notsup = (cmd[CMD_CMDTYPE_MSB:CMD_CMDTYPE_LSB] != 8'd0)
                || (transfer && (cmd[CMD_AARSIZE_MSB:CMD_AARSIZE_LSB] != AARSIZE_32))
                || cmd[CMD_POSTEXEC];

   always_comb begin
      err = CMDERR_NONE;
      if (notsup)
         err = CMDERR_NOTSUP;
      else if (!halted)
         err = CMDERR_HALTRESUME;
      else if (transfer && !(is_gpr || is_fpr))
         err = CMDERR_EXC;
   end

   assign sel_fpu = is_fpr;

   // Reserved bit, postincrement and direction are irrelevant to legality.
   assign unused_fields = ^{cmd[23], cmd[CMD_POSTINC], cmd[CMD_WRITE]};

endmodule

// File: rtl/airi5c_dm_regaccess.sv
// Abstract-command "Access Register" engine: moves data0 to/from a GPR/FPR over the
// register-file debug port and maintains busy / sticky cmderr.
//
// state  | meaning
// IDLE   | waiting for a command; accepted only while cmderr is clear
// DECODE | legality check of the latched command, address setup
// XFER   | single register-file access (write strobe or read capture)
// POST   | regno+1 written back to the command register
module airi5c_dm_regaccess
   import airi5c_dm_regaccess_pkg::*;
#(
   parameter int NUM_GPR = 32,
   parameter int HAS_FPU = 0,
   parameter int XLEN    = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cmd_valid_i,
   input  logic [31:0]     cmd_i,
   input  logic [XLEN-1:0] data0_i,
   input  logic            halted_i,
   input  logic [2:0]      cmderr_clr_i,
   output logic            busy_o,
   output logic [2:0]      cmderr_o,
   output logic [XLEN-1:0] data0_o,
   output logic            data0_we_o,
   output logic [31:0]     cmd_upd_o,
   output logic            cmd_upd_we_o,
   output logic [4:0]      dm_wara_o,
   output logic [XLEN-1:0] dm_wd_o,
   output logic            dm_wen_o,
   output logic            dm_sel_fpu_reg_o,
   input  logic [XLEN-1:0] dm_rd_i
);

   ra_state_e       state_q, state_d;
   logic [31:0]     cmd_q;
   logic [XLEN-1:0] data0_q;
   logic [XLEN-1:0] rd_q;
   logic [2:0]      cmderr_q, cmderr_d;
   logic [4:0]      wara_q;
   logic            sel_fpu_q;
   logic            accept;
   logic            load_addr;
   logic [2:0]      chk_err;
   logic            chk_sel_fpu;

   airi5c_dm_cmd_check #(
      .NUM_GPR (NUM_GPR),
      .HAS_FPU (HAS_FPU)
   ) u_cmd_check (
      .cmd     (cmd_q),
      .halted  (halted_i),
      .err     (chk_err),
      .sel_fpu (chk_sel_fpu)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         data0_q   <= '0;
         rd_q      <= '0;
         cmderr_q  <= CMDERR_NONE;
         wara_q    <= '0;
         sel_fpu_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmderr_q <= cmderr_d;
         if (accept) begin
            cmd_q   <= cmd_i;
            data0_q <= data0_i;
         end
         if (load_addr) begin
            wara_q    <= cmd_q[4:0];
            sel_fpu_q <= chk_sel_fpu;
         end
         if (data0_we_o)
            rd_q <= dm_rd_i;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      load_addr = 1'b0;
      cmderr_d  = cmderr_q & ~cmderr_clr_i;

      // An error raised this cycle wins over a simultaneous W1C clear.
      if (cmd_valid_i && (state_q != ST_IDLE) && (cmderr_q == CMDERR_NONE))
         cmderr_d = CMDERR_BUSY;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && (cmderr_q == CMDERR_NONE)) begin
               accept  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (chk_err != CMDERR_NONE) begin
               if (cmderr_q == CMDERR_NONE)
                  cmderr_d = chk_err;
               state_d = ST_IDLE;
            end else if (!cmd_q[CMD_TRANSFER]) begin
               state_d = cmd_q[CMD_POSTINC] ? ST_POST : ST_IDLE;
            end else begin
               load_addr = 1'b1;
               state_d   = ST_XFER;
            end
         end
         ST_XFER:  state_d = cmd_q[CMD_POSTINC] ? ST_POST : ST_IDLE;
         ST_POST:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign busy_o           = (state_q != ST_IDLE);
   assign cmderr_o         = cmderr_q;
   assign dm_wara_o        = wara_q;
   assign dm_sel_fpu_reg_o = sel_fpu_q;
   assign dm_wd_o          = data0_q;
   assign dm_wen_o         = (state_q == ST_XFER) &&  cmd_q[CMD_WRITE];
   assign data0_we_o       = (state_q == ST_XFER) && !cmd_q[CMD_WRITE];
   // Read data is forwarded during XFER so data0 loads on the same edge; held afterwards.
   assign data0_o          = data0_we_o ? dm_rd_i : rd_q;
   assign cmd_upd_we_o     = (state_q == ST_POST);
   assign cmd_upd_o        = cmd_upd_we_o ? {cmd_q[31:16], cmd_q[15:0] + 16'd1} : 32'd0;

endmodule

// File: tb/tb_airi5c_dm_regaccess.sv
// Directed bench for the Access Register engine: write, read, postincrement,
// error codes, busy collision, W1C clear and reset mid-command.
module tb_airi5c_dm_regaccess;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic [31:0] cmd_i;
   logic [31:0] data0_i;
   logic        halted_i;
   logic [2:0]  cmderr_clr_i;
   logic        busy_o;
   logic [2:0]  cmderr_o;
   logic [31:0] data0_o;
   logic        data0_we_o;
   logic [31:0] cmd_upd_o;
   logic        cmd_upd_we_o;
   logic [4:0]  dm_wara_o;
   logic [31:0] dm_wd_o;
   logic        dm_wen_o;
   logic        dm_sel_fpu_reg_o;
   logic [31:0] dm_rd_i;

   int checks = 0;
   int errors = 0;

   airi5c_dm_regaccess #(
      .NUM_GPR (32),
      .HAS_FPU (0),
      .XLEN    (32)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_i            (cmd_i),
      .data0_i          (data0_i),
      .halted_i         (halted_i),
      .cmderr_clr_i     (cmderr_clr_i),
      .busy_o           (busy_o),
      .cmderr_o         (cmderr_o),
      .data0_o          (data0_o),
      .data0_we_o       (data0_we_o),
      .cmd_upd_o        (cmd_upd_o),
      .cmd_upd_we_o     (cmd_upd_we_o),
      .dm_wara_o        (dm_wara_o),
      .dm_wd_o          (dm_wd_o),
      .dm_wen_o         (dm_wen_o),
      .dm_sel_fpu_reg_o (dm_sel_fpu_reg_o),
      .dm_rd_i          (dm_rd_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      cmd_valid_i  = 1'b0;
      cmd_i        = 32'd0;
      data0_i      = 32'd0;
      halted_i     = 1'b1;
      cmderr_clr_i = 3'd0;
      dm_rd_i      = 32'd0;
      tick();
      tick();
      rst_i = 1'b0;

      chk("rst_busy",   32'(busy_o), 32'd0);
      chk("rst_cmderr", 32'(cmderr_o), 32'd0);
      chk("rst_wen",    32'(dm_wen_o), 32'd0);
      chk("rst_wara",   32'(dm_wara_o), 32'd0);
      chk("rst_wd",     dm_wd_o, 32'd0);
      chk("rst_data0",  data0_o, 32'd0);
      chk("rst_upd",    cmd_upd_o, 32'd0);
      chk("rst_updwe",  32'(cmd_upd_we_o), 32'd0);
      chk("rst_d0we",   32'(data0_we_o), 32'd0);
      chk("rst_selfpu", 32'(dm_sel_fpu_reg_o), 32'd0);

      // GPR write x5
      cmd_valid_i = 1'b1; cmd_i = 32'h0023_1005; data0_i = 32'hCAFE_F00D;
      tick();
      cmd_valid_i = 1'b0; data0_i = 32'h0;
      chk("wr_dec_busy", 32'(busy_o), 32'd1);
      chk("wr_dec_wen",  32'(dm_wen_o), 32'd0);
      tick();
      chk("wr_x_busy", 32'(busy_o), 32'd1);
      chk("wr_x_wen",  32'(dm_wen_o), 32'd1);
      chk("wr_x_wara", 32'(dm_wara_o), 32'd5);
      chk("wr_x_wd",   dm_wd_o, 32'hCAFE_F00D);
      chk("wr_x_d0we", 32'(data0_we_o), 32'd0);
      tick();
      chk("wr_end_busy", 32'(busy_o), 32'd0);
      chk("wr_end_wen",  32'(dm_wen_o), 32'd0);
      chk("wr_end_wara", 32'(dm_wara_o), 32'd5);
      chk("wr_cmderr",   32'(cmderr_o), 32'd0);

      // GPR read x3
      dm_rd_i = 32'h1234_5678;
      cmd_valid_i = 1'b1; cmd_i = 32'h0022_1003;
      tick();
      cmd_valid_i = 1'b0;
      chk("rd_dec_d0we", 32'(data0_we_o), 32'd0);
      chk("rd_dec_wen",  32'(dm_wen_o), 32'd0);
      tick();
      chk("rd_x_wara",  32'(dm_wara_o), 32'd3);
      chk("rd_x_d0we",  32'(data0_we_o), 32'd1);
      chk("rd_x_data0", data0_o, 32'h1234_5678);
      chk("rd_x_wen",   32'(dm_wen_o), 32'd0);
      tick();
      dm_rd_i = 32'h0;
      chk("rd_end_busy",  32'(busy_o), 32'd0);
      chk("rd_end_d0we",  32'(data0_we_o), 32'd0);
      chk("rd_end_data0", data0_o, 32'h1234_5678);
      chk("rd_end_wen",   32'(dm_wen_o), 32'd0);

      // read x1 with postincrement
      dm_rd_i = 32'hA5A5_0001;
      cmd_valid_i = 1'b1; cmd_i = 32'h002A_1001;
      tick();
      cmd_valid_i = 1'b0;
      chk("pi_dec_busy", 32'(busy_o), 32'd1);
      tick();
      chk("pi_x_busy",  32'(busy_o), 32'd1);
      chk("pi_x_wara",  32'(dm_wara_o), 32'd1);
      chk("pi_x_d0we",  32'(data0_we_o), 32'd1);
      chk("pi_x_data0", data0_o, 32'hA5A5_0001);
      chk("pi_x_updwe", 32'(cmd_upd_we_o), 32'd0);
      tick();
      chk("pi_p_busy",  32'(busy_o), 32'd1);
      chk("pi_p_updwe", 32'(cmd_upd_we_o), 32'd1);
      chk("pi_p_upd",   cmd_upd_o, 32'h002A_1002);
      chk("pi_p_d0we",  32'(data0_we_o), 32'd0);
      tick();
      chk("pi_end_busy",  32'(busy_o), 32'd0);
      chk("pi_end_updwe", 32'(cmd_upd_we_o), 32'd0);
      dm_rd_i = 32'h0;

      // not halted -> HALTRESUME, then ignored command, then W1C clear
      halted_i = 1'b0;
      cmd_valid_i = 1'b1; cmd_i = 32'h0023_1002; data0_i = 32'h1111_2222;
      tick();
      cmd_valid_i = 1'b0;
      chk("nh_dec_busy", 32'(busy_o), 32'd1);
      chk("nh_dec_wen",  32'(dm_wen_o), 32'd0);
      tick();
      chk("nh_busy",   32'(busy_o), 32'd0);
      chk("nh_cmderr", 32'(cmderr_o), 32'd4);
      chk("nh_wen",    32'(dm_wen_o), 32'd0);
      halted_i = 1'b1;
      cmd_valid_i = 1'b1; cmd_i = 32'h0023_1005;
      tick();
      cmd_valid_i = 1'b0;
      chk("ign_busy",   32'(busy_o), 32'd0);
      chk("ign_cmderr", 32'(cmderr_o), 32'd4);
      tick();
      chk("ign_wen", 32'(dm_wen_o), 32'd0);
      cmderr_clr_i = 3'b111;
      tick();
      cmderr_clr_i = 3'b000;
      chk("clr_cmderr", 32'(cmderr_o), 32'd0);

      // aarsize=3 -> NOTSUP
      cmd_valid_i = 1'b1; cmd_i = 32'h0033_1002;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      chk("sz_cmderr", 32'(cmderr_o), 32'd2);
      chk("sz_busy",   32'(busy_o), 32'd0);
      chk("sz_wen",    32'(dm_wen_o), 32'd0);
      cmderr_clr_i = 3'b111;
      tick();
      cmderr_clr_i = 3'b000;
      chk("sz_clr", 32'(cmderr_o), 32'd0);

      // FPR regno without FPU -> EXC
      cmd_valid_i = 1'b1; cmd_i = 32'h0022_1021;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      chk("fpr_cmderr", 32'(cmderr_o), 32'd3);
      chk("fpr_d0we",   32'(data0_we_o), 32'd0);
      chk("fpr_selfpu", 32'(dm_sel_fpu_reg_o), 32'd0);
      cmderr_clr_i = 3'b111;
      tick();
      cmderr_clr_i = 3'b000;

      // second command while busy -> BUSY, first write still completes
      cmd_valid_i = 1'b1; cmd_i = 32'h0023_1005; data0_i = 32'h0BAD_BEEF;
      tick();
      chk("col_dec_busy", 32'(busy_o), 32'd1);
      cmd_i = 32'h0023_1007; data0_i = 32'h0;
      tick();
      cmd_valid_i = 1'b0;
      chk("col_cmderr", 32'(cmderr_o), 32'd1);
      chk("col_wen",    32'(dm_wen_o), 32'd1);
      chk("col_wara",   32'(dm_wara_o), 32'd5);
      chk("col_wd",     dm_wd_o, 32'h0BAD_BEEF);
      tick();
      chk("col_end_busy", 32'(busy_o), 32'd0);
      chk("col_end_err",  32'(cmderr_o), 32'd1);
      cmderr_clr_i = 3'b001;
      tick();
      cmderr_clr_i = 3'b000;
      chk("col_clr", 32'(cmderr_o), 32'd0);

      // reset while in DECODE aborts the write
      cmd_valid_i = 1'b1; cmd_i = 32'h0023_1009; data0_i = 32'h5555_AAAA;
      tick();
      cmd_valid_i = 1'b0;
      chk("rs_dec_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      tick();
      chk("rs_busy", 32'(busy_o), 32'd0);
      chk("rs_wen",  32'(dm_wen_o), 32'd0);
      chk("rs_wara", 32'(dm_wara_o), 32'd0);
      rst_i = 1'b0;
      tick();
      chk("rs_after_wen",  32'(dm_wen_o), 32'd0);
      chk("rs_after_busy", 32'(busy_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
